// File: rtl/am_stim_pkg.sv
// am_stim_pkg: shared widths, pipeline constants and sine table generator
// for the AM stimulus generator.
package am_stim_pkg;

    localparam int PHASE_W_D = 24;
    localparam int SIN_W_D   = 16;
    localparam int LUT_AW_D  = 10;
    localparam int OUT_W_D   = 14;
    localparam int DEPTH_W_D = 8;

    localparam int OUT_SHIFT = 2 * SIN_W_D - OUT_W_D;
    localparam int PIPE_LAT  = 4;

    // Quarter-wave entry k, sampled mid-bin so the mirrored quadrants stay exact.
    function automatic int qsin(input int k, input int sin_w, input int lut_aw);
        real ang;
        real amp;
        ang = 2.0 * 3.14159265358979 * ($itor(k) + 0.5) / (2.0 ** lut_aw);
        amp = (2.0 ** (sin_w - 1)) - 1.0;
        return $rtoi(amp * $sin(ang) + 0.5);
    endfunction

endpackage

// File: rtl/am_sine_lut.sv
// am_sine_lut: quarter-wave sine ROM with quadrant mirror/negate,
// NP independent ports sharing one table, registered read.
import am_stim_pkg::*;

module am_sine_lut #(
    parameter int SIN_W  = SIN_W_D,
    parameter int LUT_AW = LUT_AW_D,
    parameter int NP     = 2
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         en_i,
    input  logic [NP-1:0][LUT_AW-1:0]    addr_i,
    output logic [NP-1:0][SIN_W-1:0]     data_o
);

    localparam int QN = 2 ** (LUT_AW - 2);

    logic [SIN_W-1:0] rom [QN];

    for (genvar k = 0; k < QN; k++) begin : g_rom
        assign rom[k] = SIN_W'(qsin(k, SIN_W, LUT_AW));
    end

    for (genvar p = 0; p < NP; p++) begin : g_port
        logic [LUT_AW-3:0] idx;
        logic [SIN_W-1:0]  mag;
        logic [SIN_W-1:0]  data_q;

        // Odd quadrants walk the table backwards; the upper half is negated.
        assign idx = addr_i[p][LUT_AW-2] ? ~addr_i[p][LUT_AW-3:0]
                                         : addr_i[p][LUT_AW-3:0];
        assign mag = rom[idx];

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                data_q <= '0;
            end else if (en_i) begin
                data_q <= addr_i[p][LUT_AW-1] ? -mag : mag;
            end
        end

        assign data_o[p] = data_q;
    end

endmodule

// File: rtl/am_stim_gen.sv
// am_stim_gen: sine carrier amplitude-modulated by a sine tone, 4-clk pipeline.
// Define AM_INTERFERENCE_EN to mix a third (interference) tone into the envelope.
import am_stim_pkg::*;

module am_stim_gen #(
    parameter int PHASE_W = PHASE_W_D,
    parameter int SIN_W   = SIN_W_D,
    parameter int LUT_AW  = LUT_AW_D,
    parameter int OUT_W   = OUT_W_D,
    parameter int DEPTH_W = DEPTH_W_D
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      ce,
    input  logic                      run,
    input  logic                      cfg_load,
    input  logic [PHASE_W-1:0]        car_inc,
    input  logic [PHASE_W-1:0]        bb_inc,
    input  logic [DEPTH_W-1:0]        depth,
    input  logic [PHASE_W-1:0]        intf_inc,
    output logic signed [OUT_W-1:0]   out_sample,
    output logic                      out_valid
);

`ifdef AM_INTERFERENCE_EN
    localparam int NP = 3;
`else
    localparam int NP = 2;
`endif
    localparam int MW    = SIN_W + DEPTH_W + 1;
    localparam int PW    = 2 * SIN_W + 1;
    localparam int SHIFT = 2 * SIN_W - OUT_W;
    localparam logic signed [SIN_W:0] ENV_BIAS = {2'b01, {(SIN_W-1){1'b0}}};

    logic [NP-1:0][PHASE_W-1:0] inc_in, inc_q, acc_q, acc_d;
    logic [NP-1:0][LUT_AW-1:0]  addr;
    logic [NP-1:0][SIN_W-1:0]   wave;
    logic [DEPTH_W-1:0]         depth_q;
    logic [PIPE_LAT:0]          vld_q;
    logic signed [SIN_W-1:0]    bb_eff, car_q;
    logic signed [MW-1:0]       mod_full, mod_sh;
    logic signed [SIN_W:0]      env_d, env_q;
    logic signed [PW-1:0]       prod_d, prod_q;
    logic signed [OUT_W-1:0]    out_q;
    logic                       unused_bits;

`ifdef AM_INTERFERENCE_EN
    assign inc_in = {intf_inc, bb_inc, car_inc};
    assign bb_eff = ($signed(wave[1]) >>> 1) + ($signed(wave[2]) >>> 1);
`else
    logic unused_intf;
    assign unused_intf = ^intf_inc;
    assign inc_in = {bb_inc, car_inc};
    assign bb_eff = $signed(wave[1]);
`endif

    always_comb begin
        acc_d = acc_q;
        for (int i = 0; i < NP; i++) begin
            if (!run) begin
                acc_d[i] = '0;
            end else if (ce) begin
                acc_d[i] = acc_q[i] + inc_q[i];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_q   <= '0;
            inc_q   <= '0;
            depth_q <= '0;
            vld_q   <= '0;
        end else begin
            acc_q <= acc_d;
            vld_q <= {vld_q[PIPE_LAT-1:0], ce & run};
            if (cfg_load) begin
                inc_q   <= inc_in;
                depth_q <= depth;
            end
        end
    end

    for (genvar i = 0; i < NP; i++) begin : g_addr
        assign addr[i] = acc_q[i][PHASE_W-1 -: LUT_AW];
    end

    am_sine_lut #(
        .SIN_W  (SIN_W),
        .LUT_AW (LUT_AW),
        .NP     (NP)
    ) u_lut (
        .clk     (clk),
        .reset_n (reset_n),
        .en_i    (vld_q[0]),
        .addr_i  (addr),
        .data_o  (wave)
    );

    // Envelope stays strictly positive: |bb*depth| >> DEPTH_W < 2^(SIN_W-1).
    assign mod_full = MW'(bb_eff) * MW'($signed({1'b0, depth_q}));
    assign mod_sh   = mod_full >>> DEPTH_W;
    assign env_d    = ENV_BIAS + $signed(mod_sh[SIN_W:0]);
    assign prod_d   = PW'(env_q) * PW'(car_q);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            env_q  <= '0;
            car_q  <= '0;
            prod_q <= '0;
            out_q  <= '0;
        end else begin
            if (vld_q[1]) begin
                env_q <= env_d;
                car_q <= wave[0];
            end
            if (vld_q[2]) begin
                prod_q <= prod_d;
            end
            if (vld_q[3]) begin
                out_q <= prod_q[SHIFT +: OUT_W];
            end
        end
    end

    assign unused_bits = ^{mod_sh[MW-1:SIN_W+1], prod_q[PW-1:SHIFT+OUT_W],
                           prod_q[SHIFT-1:0]};

    assign out_sample = out_q;
    assign out_valid  = vld_q[PIPE_LAT];

endmodule
